// File: rtl/exec_defs.sv
// rtl/exec_defs.sv - shared opcode, ALU_OP and FSM state definitions for exec_ctrl
// Contents: state_t (IDLE/DECODE/EXEC/WB), opcode and ALU_OP constants, alu_op_of().
package exec_defs;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    // Instruction opcodes; any opcode with bit 2 set is an ADD.
    localparam logic [2:0] OPC_MOV   = 3'b000;
    localparam logic [2:0] OPC_SHIFT = 3'b001;
    localparam logic [2:0] OPC_BNEG  = 3'b010;
    localparam logic [2:0] OPC_NOR   = 3'b011;

    // ALU_OP encodings; ALU_NONE is what MOV drives since it bypasses the ALU.
    localparam logic [2:0] ALU_NONE  = 3'b000;
    localparam logic [2:0] ALU_SHIFT = 3'b001;
    localparam logic [2:0] ALU_BNEG  = 3'b010;
    localparam logic [2:0] ALU_NOR   = 3'b011;
    localparam logic [2:0] ALU_ADD   = 3'b100;

    function automatic logic [2:0] alu_op_of(input logic [2:0] opcode);
        logic [2:0] op;
        case (opcode)
            OPC_MOV:   op = ALU_NONE;
            OPC_SHIFT: op = ALU_SHIFT;
            OPC_BNEG:  op = ALU_BNEG;
            OPC_NOR:   op = ALU_NOR;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8x8 register file, two read ports, one write port, debug read port
// Ports: clk, reset (sync active-high, clears all entries), we/waddr/wdata write port,
//        raddr_a/rdata_a and raddr_b/rdata_b operand reads, dbg_addr/dbg_data debug read.
// All reads are combinational, so a write becomes visible only after its clock edge.
module reg_file (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr_a,
    input  logic [2:0] raddr_b,
    input  logic [2:0] dbg_addr,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b,
    output logic [7:0] dbg_data
);

    logic [7:0] regs [8];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - four-state (IDLE/DECODE/EXEC/WB) execution controller driving an external ALU
// Ports: CLK, Reset (sync active-high); InstValid/Inst/InstReady instruction handshake;
//        ALU_A/ALU_B/ALU_OP to the ALU, ALU_Out/ALU_Zero back; Done/BranchTaken pulses,
//        ZeroFlag; PreWr/PreAddr/PreData preload port (IDLE only); DbgAddr/DbgData debug read.
module exec_ctrl
    import exec_defs::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic       InstValid,
    input  logic [8:0] Inst,
    output logic       InstReady,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic [2:0] ALU_OP,
    input  logic [7:0] ALU_Out,
    input  logic       ALU_Zero,
    output logic       Done,
    output logic       BranchTaken,
    output logic       ZeroFlag,
    input  logic       PreWr,
    input  logic [2:0] PreAddr,
    input  logic [7:0] PreData,
    input  logic [2:0] DbgAddr,
    output logic [7:0] DbgData
);

    state_t     state, state_nxt;
    logic [2:0] alu_op_q, rd_q;
    logic [7:0] op_a_q, op_b_q, res_q;
    logic       res_zero_q, done_q, branch_q, zero_flag_q;

    logic       accept, drive_alu;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata, rf_rdata_a, rf_rdata_b;

    assign InstReady = (state == S_IDLE);
    assign accept    = InstValid && InstReady;

    // The WB write and the preload are mutually exclusive by state.
    assign rf_we    = ((state == S_WB) && (alu_op_q != ALU_BNEG)) || ((state == S_IDLE) && PreWr);
    assign rf_waddr = (state == S_WB) ? rd_q  : PreAddr;
    assign rf_wdata = (state == S_WB) ? res_q : PreData;

    reg_file u_reg_file (
        .clk      (CLK),
        .reset    (Reset),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr_a  (Inst[5:3]),
        .raddr_b  (Inst[2:0]),
        .dbg_addr (DbgAddr),
        .rdata_a  (rf_rdata_a),
        .rdata_b  (rf_rdata_b),
        .dbg_data (DbgData)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Operands are sampled on the accept edge and held through DECODE: a preload
    // landing on that same edge must not be seen by the accepted instruction.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            alu_op_q    <= ALU_NONE;
            rd_q        <= 3'd0;
            op_a_q      <= 8'h00;
            op_b_q      <= 8'h00;
            res_q       <= 8'h00;
            res_zero_q  <= 1'b0;
            done_q      <= 1'b0;
            branch_q    <= 1'b0;
            zero_flag_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            branch_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_op_q <= alu_op_of(Inst[8:6]);
                        rd_q     <= Inst[5:3];
                        op_a_q   <= rf_rdata_a;
                        op_b_q   <= rf_rdata_b;
                    end
                end
                S_EXEC: begin
                    res_q      <= (alu_op_q == ALU_NONE) ? op_b_q : ALU_Out;
                    res_zero_q <= ALU_Zero;
                end
                S_WB: begin
                    done_q   <= 1'b1;
                    branch_q <= (alu_op_q == ALU_BNEG) && (res_q == 8'h00);
                    if (alu_op_q != ALU_NONE) begin
                        zero_flag_q <= res_zero_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign drive_alu   = (state == S_EXEC) || (state == S_WB);
    assign ALU_A       = drive_alu ? op_a_q   : 8'h00;
    assign ALU_B       = drive_alu ? op_b_q   : 8'h00;
    assign ALU_OP      = drive_alu ? alu_op_q : 3'b000;
    assign Done        = done_q;
    assign BranchTaken = branch_q;
    assign ZeroFlag    = zero_flag_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// tb/tb_exec_ctrl.sv - self-checking bench for exec_ctrl with a behavioural ALU model
module tb_exec_ctrl;

    logic       CLK = 1'b0;
    logic       Reset, InstValid, PreWr;
    logic [8:0] Inst;
    logic       InstReady, Done, BranchTaken, ZeroFlag;
    logic [7:0] ALU_A, ALU_B, ALU_Out, PreData, DbgData;
    logic [2:0] ALU_OP, PreAddr, DbgAddr;
    logic       ALU_Zero;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    exec_ctrl dut (
        .CLK(CLK), .Reset(Reset), .InstValid(InstValid), .Inst(Inst), .InstReady(InstReady),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_Out(ALU_Out), .ALU_Zero(ALU_Zero),
        .Done(Done), .BranchTaken(BranchTaken), .ZeroFlag(ZeroFlag),
        .PreWr(PreWr), .PreAddr(PreAddr), .PreData(PreData),
        .DbgAddr(DbgAddr), .DbgData(DbgData)
    );

    // Behavioural ALU: SHIFT uses B[3] for direction and B[2:0] for amount;
    // BNEG yields zero when A is negative so the controller sees "taken" as result==0.
    always_comb begin
        ALU_Out = 8'h00;
        case (ALU_OP)
            3'b100:  ALU_Out = ALU_A + ALU_B;
            3'b011:  ALU_Out = ~(ALU_A | ALU_B);
            3'b001:  ALU_Out = ALU_B[3] ? 8'($signed(ALU_A) >>> ALU_B[2:0]) : 8'(ALU_A << ALU_B[2:0]);
            3'b010:  ALU_Out = ALU_A[7] ? 8'h00 : 8'h01;
            default: ALU_Out = 8'h00;
        endcase
    end
    assign ALU_Zero = (ALU_Out == 8'h00);

    typedef struct {
        logic [2:0] opc;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] va;
        logic [7:0] vb;
        logic [2:0] exp_op;
        logic [7:0] exp_rd;
        logic       exp_br;
        logic       exp_z;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        PreWr = 1'b1; PreAddr = a; PreData = d;
        tick();
        PreWr = 1'b0;
    endtask

    initial begin
        int accepts;
        logic [7:0] ready_pat;

        vecs[0] = '{3'b011, 3'd1, 3'd2, 8'h2D, 8'hB4, 3'b011, 8'h42, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 3'd1, 3'd2, 8'h5C, 8'h04, 3'b001, 8'hC0, 1'b0, 1'b0};
        vecs[2] = '{3'b001, 3'd1, 3'd2, 8'h5C, 8'h0C, 3'b001, 8'h05, 1'b0, 1'b0};
        vecs[3] = '{3'b010, 3'd1, 3'd2, 8'hDC, 8'h00, 3'b010, 8'hDC, 1'b1, 1'b1};
        vecs[4] = '{3'b010, 3'd1, 3'd2, 8'h5C, 8'h00, 3'b010, 8'h5C, 1'b0, 1'b0};
        vecs[5] = '{3'b100, 3'd3, 3'd4, 8'h1C, 8'h89, 3'b100, 8'hA5, 1'b0, 1'b0};
        vecs[6] = '{3'b111, 3'd3, 3'd4, 8'h1C, 8'hE4, 3'b100, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{3'b000, 3'd5, 3'd6, 8'h11, 8'h77, 3'b000, 8'h77, 1'b0, 1'b1};

        Reset = 1'b1; InstValid = 1'b0; Inst = 9'd0;
        PreWr = 1'b0; PreAddr = 3'd0; PreData = 8'h00; DbgAddr = 3'd0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_ready", InstReady, 1);
        chk("rst_done", Done, 0);
        chk("rst_branch", BranchTaken, 0);
        chk("rst_zero", ZeroFlag, 0);
        chk("rst_alu", {ALU_A, ALU_B, ALU_OP}, 0);
        chk("rst_r0", DbgData, 0);

        for (int v = 0; v < 8; v++) begin
            preload(vecs[v].rd, vecs[v].va);
            preload(vecs[v].rs, vecs[v].vb);
            DbgAddr = vecs[v].rd;
            chk($sformatf("v%0d_ready_idle", v), InstReady, 1);
            Inst = {vecs[v].opc, vecs[v].rd, vecs[v].rs};
            InstValid = 1'b1;
            tick();
            InstValid = 1'b0;
            chk($sformatf("v%0d_ready_decode", v), InstReady, 0);
            tick();
            chk($sformatf("v%0d_alu_op", v), ALU_OP, vecs[v].exp_op);
            tick();
            chk($sformatf("v%0d_wb_done", v), Done, 0);
            chk($sformatf("v%0d_wb_dbg_old", v), DbgData, vecs[v].va);
            tick();
            chk($sformatf("v%0d_done", v), Done, 1);
            chk($sformatf("v%0d_branch", v), BranchTaken, vecs[v].exp_br);
            chk($sformatf("v%0d_rd", v), DbgData, vecs[v].exp_rd);
            chk($sformatf("v%0d_zero", v), ZeroFlag, vecs[v].exp_z);
            chk($sformatf("v%0d_ready_after", v), InstReady, 1);
            tick();
            chk($sformatf("v%0d_done_pulse", v), Done, 0);
        end

        // InstValid held for 8 cycles: accepts only when ready, no queueing.
        ready_pat = 8'b0001_0001;
        accepts = 0;
        Inst = 9'b000_111_111;
        InstValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("held_ready_%0d", i), InstReady, ready_pat[i]);
            if (InstReady && InstValid) accepts++;
            if (i == 7) InstValid = 1'b0;
            tick();
        end
        chk("held_accepts", accepts, 2);
        chk("held_ready_end", InstReady, 1);

        // PreWr outside IDLE is dropped.
        preload(3'd6, 8'h33);
        Inst = 9'b000_111_111;
        InstValid = 1'b1;
        tick();
        InstValid = 1'b0;
        PreWr = 1'b1; PreAddr = 3'd6; PreData = 8'hEE;
        tick(); tick();
        PreWr = 1'b0;
        tick(); tick();
        DbgAddr = 3'd6;
        chk("prewr_busy_ignored", DbgData, 8'h33);

        // Reset during EXEC of an ADD aborts it.
        preload(3'd3, 8'h1C);
        preload(3'd4, 8'h89);
        Inst = 9'b100_011_100;
        InstValid = 1'b1;
        tick();
        InstValid = 1'b0;
        tick();
        chk("abort_in_exec", ALU_OP, 3'b100);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_ready", InstReady, 1);
        chk("abort_alu", {ALU_A, ALU_B, ALU_OP}, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_no_done_%0d", i), Done, 0);
            tick();
        end
        chk("abort_zero", ZeroFlag, 0);
        for (int r = 0; r < 8; r++) begin
            DbgAddr = 3'(r);
            #1;
            chk($sformatf("abort_r%0d", r), DbgData, 0);
        end

        // Preload coinciding with accept: preload lands, instruction uses old value.
        preload(3'd1, 8'h10);
        preload(3'd2, 8'h20);
        DbgAddr = 3'd1;
        Inst = 9'b100_001_010;
        InstValid = 1'b1;
        PreWr = 1'b1; PreAddr = 3'd1; PreData = 8'h50;
        tick();
        InstValid = 1'b0;
        PreWr = 1'b0;
        chk("same_cycle_preload", DbgData, 8'h50);
        tick(); tick(); tick();
        chk("same_cycle_done", Done, 1);
        chk("same_cycle_old_operand", DbgData, 8'h30);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
